axi_rd_arbiter: RTL

- Shares the core's single AXI read channel between the instruction-fetch requester and the data-load (MEM stage) requester.
- Grants one requester at a time and sequences the AR and R handshakes, with one transaction outstanding.
- Returns read data to the granted requester as a one-cycle valid pulse.
- Supports fetch flush: an in-flight instruction read completes on the bus but is dropped, not delivered.

---
 rtl/axi_rd_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between instruction fetch and data load, one transaction outstanding.
// Optional macro ARB_RR_EN: round-robin arbitration; otherwise fixed priority, data over inst.
module axi_rd_arbiter #(
    parameter logic [3:0] INST_ID = 4'h0,
    parameter logic [3:0] DATA_ID = 4'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        inst_flush,
    output logic [31:0] inst_rdata,
    output logic        inst_rvalid,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [2:0]  data_size,
    output logic [31:0] data_rdata,
    output logic        data_rvalid,
    output logic        busy,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [2:0] {IDLE, AR_INST, AR_DATA, R_INST, R_DATA} state_e;

    state_e      state_q;
    logic [31:0] addr_q;
    logic [2:0]  size_q;
    logic [3:0]  id_q;
    logic        drop_q;
    logic [31:0] inst_rdata_q;
    logic [31:0] data_rdata_q;
    logic        inst_rvalid_q;
    logic        data_rvalid_q;

    logic        inst_elig;
    logic        grant_data;
    logic        grant_inst;
    logic        beat;
    logic [31:0] beat_data;

    // rid carries no information with a single outstanding transaction.
    logic unused_rid;
    assign unused_rid = ^rid;

    // A flush in IDLE removes the fetch from arbitration for that cycle.
    assign inst_elig = inst_req && !inst_flush;

`ifdef ARB_RR_EN
    logic last_grant_q;  // 0 = inst, 1 = data
    assign grant_data = data_req && (!inst_elig || !last_grant_q);
`else
    assign grant_data = data_req;
`endif
    assign grant_inst = inst_elig && !grant_data;

    assign beat      = rvalid && rlast;
    assign beat_data = (rresp == 2'b00) ? rdata : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            size_q        <= '0;
            id_q          <= '0;
            drop_q        <= 1'b0;
            inst_rdata_q  <= '0;
            data_rdata_q  <= '0;
            inst_rvalid_q <= 1'b0;
            data_rvalid_q <= 1'b0;
`ifdef ARB_RR_EN
            last_grant_q  <= 1'b0;
`endif
        end else begin
            inst_rvalid_q <= 1'b0;
            data_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    drop_q <= 1'b0;
                    if (grant_data) begin
                        state_q <= AR_DATA;
                        addr_q  <= data_addr;
                        size_q  <= data_size;
                        id_q    <= DATA_ID;
`ifdef ARB_RR_EN
                        last_grant_q <= 1'b1;
`endif
                    end else if (grant_inst) begin
                        state_q <= AR_INST;
                        addr_q  <= inst_addr;
                        size_q  <= 3'b010;
                        id_q    <= INST_ID;
`ifdef ARB_RR_EN
                        last_grant_q <= 1'b0;
`endif
                    end
                end
                AR_INST: begin
                    if (inst_flush) drop_q <= 1'b1;
                    if (arready) state_q <= R_INST;
                end
                AR_DATA: begin
                    if (arready) state_q <= R_DATA;
                end
                R_INST: begin
                    if (inst_flush) drop_q <= 1'b1;
                    if (beat) begin
                        state_q <= IDLE;
                        drop_q  <= 1'b0;
                        // A flush on the beat cycle itself also suppresses delivery.
                        if (!drop_q && !inst_flush) begin
                            inst_rdata_q  <= beat_data;
                            inst_rvalid_q <= 1'b1;
                        end
                    end
                end
                R_DATA: begin
                    if (beat) begin
                        state_q       <= IDLE;
                        data_rdata_q  <= beat_data;
                        data_rvalid_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshakes: a transfer occurs on a rising clk edge where valid && ready; arvalid and the AR
    // fields hold stable until arready, and rready is held for the whole R phase.
    assign arvalid     = (state_q == AR_INST) || (state_q == AR_DATA);
    assign rready      = (state_q == R_INST) || (state_q == R_DATA);
    assign busy        = (state_q != IDLE);
    assign arid        = id_q;
    assign araddr      = addr_q;
    assign arsize      = size_q;
    assign arlen       = 8'd0;
    assign arburst     = arvalid ? 2'b01 : 2'b00;
    assign inst_rdata  = inst_rdata_q;
    assign inst_rvalid = inst_rvalid_q;
    assign data_rdata  = data_rdata_q;
    assign data_rvalid = data_rvalid_q;

endmodule
